// File: rtl/avalon_mm_pipeline_bridge.sv
// Single-clock Avalon-MM slave-to-master bridge: show-ahead command FIFO, credit-gated
// reads, fall-through response queue, outstanding-read counter and unexpected-response flag.
module avalon_mm_pipeline_bridge #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 25,
    parameter int unsigned CMD_DEPTH = 8,
    parameter int unsigned RSP_DEPTH = 16
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [ADDR_W-1:0]                     slave_address,
    input  logic [DATA_W/8-1:0]                   slave_byteenable,
    input  logic                                  slave_read,
    input  logic                                  slave_write,
    input  logic [DATA_W-1:0]                     slave_writedata,
    output logic                                  slave_waitrequest,
    output logic [DATA_W-1:0]                     slave_readdata,
    output logic                                  slave_readdatavalid,
    output logic                                  slave_endofpacket,
    output logic [ADDR_W+$clog2(DATA_W/8)-1:0]    master_address,
    output logic [ADDR_W-1:0]                     master_nativeaddress,
    output logic [DATA_W/8-1:0]                   master_byteenable,
    output logic                                  master_read,
    output logic                                  master_write,
    output logic [DATA_W-1:0]                     master_writedata,
    input  logic                                  master_waitrequest,
    input  logic [DATA_W-1:0]                     master_readdata,
    input  logic                                  master_readdatavalid,
    input  logic                                  master_endofpacket,
    output logic [$clog2(RSP_DEPTH):0]            reads_pending,
    output logic                                  err_unexpected_rsp
);

    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned BE_LOG  = $clog2(BE_W);
    localparam int unsigned MADDR_W = ADDR_W + BE_LOG;
    localparam int unsigned CMD_AW  = $clog2(CMD_DEPTH);
    localparam int unsigned CMD_CW  = CMD_AW + 1;
    localparam int unsigned RSP_AW  = $clog2(RSP_DEPTH);
    localparam int unsigned RSP_CW  = RSP_AW + 1;
    localparam int unsigned SUM_W   = RSP_CW + 1;

    typedef struct packed {
        logic [DATA_W-1:0] wdata;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic              rd;
        logic              wr;
    } cmd_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              eop;
    } rsp_t;

    cmd_t              r_cmd_mem [CMD_DEPTH];
    logic [CMD_AW-1:0] r_cmd_wptr;
    logic [CMD_AW-1:0] r_cmd_rptr;
    logic [CMD_CW-1:0] r_cmd_count;

    rsp_t              r_rsp_mem [RSP_DEPTH];
    logic [RSP_AW-1:0] r_rsp_wptr;
    logic [RSP_AW-1:0] r_rsp_rptr;
    logic [RSP_CW-1:0] r_rsp_count;

    logic [RSP_CW-1:0] r_reads_pending;
    logic              r_err;
    logic [DATA_W-1:0] r_slave_rdata;
    logic              r_slave_eop;
    logic              r_slave_rdv;

    cmd_t              w_cmd_in;
    cmd_t              w_head;
    logic              w_cmd_empty;
    logic              w_cmd_push;
    logic              w_cmd_pop;
    logic              w_credit;
    logic [SUM_W-1:0]  w_inflight;
    logic              w_rd_issue;
    logic              w_rsp_in;
    logic              w_rsp_unexp;
    logic              w_rsp_nonempty;
    logic              w_rsp_push;
    logic              w_rsp_pop;

    // Command FIFO: show-ahead head drives the master port directly
    always_comb begin
        w_cmd_in       = '0;
        w_cmd_in.wdata = slave_writedata;
        w_cmd_in.addr  = slave_address;
        w_cmd_in.be    = slave_byteenable;
        w_cmd_in.rd    = slave_read;
        w_cmd_in.wr    = slave_write;
    end

    assign slave_waitrequest = (r_cmd_count == CMD_CW'(CMD_DEPTH));
    assign w_cmd_empty       = (r_cmd_count == '0);
    assign w_cmd_push        = (slave_read | slave_write) & ~slave_waitrequest;
    assign w_head            = r_cmd_mem[r_cmd_rptr];

    assign w_inflight = SUM_W'(r_reads_pending) + SUM_W'(r_rsp_count);
    assign w_credit   = (w_inflight < SUM_W'(RSP_DEPTH));

    assign master_read          = ~w_cmd_empty & w_head.rd & w_credit;
    assign master_write         = ~w_cmd_empty & w_head.wr;
    assign master_nativeaddress = w_head.addr;
    assign master_address       = MADDR_W'(w_head.addr) << BE_LOG;
    assign master_byteenable    = w_head.be;
    assign master_writedata     = w_head.wdata;

    assign w_cmd_pop  = (master_read | master_write) & ~master_waitrequest;
    assign w_rd_issue = master_read & ~master_waitrequest;

    always_ff @(posedge clk) begin
        if (w_cmd_push) begin
            r_cmd_mem[r_cmd_wptr] <= w_cmd_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd_wptr  <= '0;
            r_cmd_rptr  <= '0;
            r_cmd_count <= '0;
        end else begin
            if (w_cmd_push) begin
                r_cmd_wptr <= r_cmd_wptr + 1'b1;
            end
            if (w_cmd_pop) begin
                r_cmd_rptr <= r_cmd_rptr + 1'b1;
            end
            case ({w_cmd_push, w_cmd_pop})
                2'b10:   r_cmd_count <= r_cmd_count + 1'b1;
                2'b01:   r_cmd_count <= r_cmd_count - 1'b1;
                default: r_cmd_count <= r_cmd_count;
            endcase
        end
    end

    // Outstanding reads and protocol error
    assign w_rsp_in    = master_readdatavalid & (r_reads_pending != '0);
    assign w_rsp_unexp = master_readdatavalid & (r_reads_pending == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reads_pending <= '0;
            r_err           <= 1'b0;
        end else begin
            case ({w_rd_issue, w_rsp_in})
                2'b10:   r_reads_pending <= r_reads_pending + 1'b1;
                2'b01:   r_reads_pending <= r_reads_pending - 1'b1;
                default: r_reads_pending <= r_reads_pending;
            endcase
            if (w_rsp_unexp) begin
                r_err <= 1'b1;
            end
        end
    end

    // Incoming word bypasses the queue when it is empty, giving one-cycle response latency
    assign w_rsp_nonempty = (r_rsp_count != '0);
    assign w_rsp_pop      = w_rsp_nonempty;
    assign w_rsp_push     = w_rsp_in & w_rsp_nonempty;

    always_ff @(posedge clk) begin
        if (w_rsp_push) begin
            r_rsp_mem[r_rsp_wptr] <= '{data: master_readdata, eop: master_endofpacket};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_wptr    <= '0;
            r_rsp_rptr    <= '0;
            r_rsp_count   <= '0;
            r_slave_rdv   <= 1'b0;
            r_slave_rdata <= '0;
            r_slave_eop   <= 1'b0;
        end else begin
            if (w_rsp_push) begin
                r_rsp_wptr <= r_rsp_wptr + 1'b1;
            end
            if (w_rsp_pop) begin
                r_rsp_rptr <= r_rsp_rptr + 1'b1;
            end
            case ({w_rsp_push, w_rsp_pop})
                2'b10:   r_rsp_count <= r_rsp_count + 1'b1;
                2'b01:   r_rsp_count <= r_rsp_count - 1'b1;
                default: r_rsp_count <= r_rsp_count;
            endcase
            r_slave_rdv <= w_rsp_nonempty | w_rsp_in;
            if (w_rsp_nonempty) begin
                r_slave_rdata <= r_rsp_mem[r_rsp_rptr].data;
                r_slave_eop   <= r_rsp_mem[r_rsp_rptr].eop;
            end else if (w_rsp_in) begin
                r_slave_rdata <= master_readdata;
                r_slave_eop   <= master_endofpacket;
            end
        end
    end

    assign slave_readdata      = r_slave_rdata;
    assign slave_endofpacket   = r_slave_eop;
    assign slave_readdatavalid = r_slave_rdv;
    assign reads_pending       = r_reads_pending;
    assign err_unexpected_rsp  = r_err;

endmodule

// File: tb/tb_avalon_mm_pipeline_bridge.sv
// Bench for avalon_mm_pipeline_bridge: directed vector table, multi-cycle corner sequences,
// then randomized traffic checked against a queue-based transaction model.
module tb_avalon_mm_pipeline_bridge;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 25;
    localparam int unsigned CMD_DEPTH = 8;
    localparam int unsigned RSP_DEPTH = 16;

    logic        clk;
    logic        reset_n;
    logic [24:0] slave_address;
    logic [3:0]  slave_byteenable;
    logic        slave_read;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        slave_waitrequest;
    logic [31:0] slave_readdata;
    logic        slave_readdatavalid;
    logic        slave_endofpacket;
    logic [26:0] master_address;
    logic [24:0] master_nativeaddress;
    logic [3:0]  master_byteenable;
    logic        master_read;
    logic        master_write;
    logic [31:0] master_writedata;
    logic        master_waitrequest;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_endofpacket;
    logic [4:0]  reads_pending;
    logic        err_unexpected_rsp;

    avalon_mm_pipeline_bridge #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .slave_address(slave_address), .slave_byteenable(slave_byteenable),
        .slave_read(slave_read), .slave_write(slave_write),
        .slave_writedata(slave_writedata), .slave_waitrequest(slave_waitrequest),
        .slave_readdata(slave_readdata), .slave_readdatavalid(slave_readdatavalid),
        .slave_endofpacket(slave_endofpacket),
        .master_address(master_address), .master_nativeaddress(master_nativeaddress),
        .master_byteenable(master_byteenable), .master_read(master_read),
        .master_write(master_write), .master_writedata(master_writedata),
        .master_waitrequest(master_waitrequest), .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid), .master_endofpacket(master_endofpacket),
        .reads_pending(reads_pending), .err_unexpected_rsp(err_unexpected_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [24:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        eop;
        logic [26:0] exp_maddr;
    } vec_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [24:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } cmd_t;

    int errors = 0;
    int checks = 0;

    // Transaction-level model state
    bit          ref_en = 0;
    cmd_t        exp_cmd[$];
    int          model_pend = 0;
    int          dn_owed = 0;
    bit          exp_rv = 0;
    logic [31:0] exp_rd = '0;
    logic        exp_eop = 1'b0;
    bit          stall_prev = 0;
    logic [33:0] snap_ctl = '0;
    logic [31:0] snap_data = '0;
    bit          up_acc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic up_idle();
        slave_read       = 1'b0;
        slave_write      = 1'b0;
        slave_address    = '0;
        slave_byteenable = '0;
        slave_writedata  = '0;
    endtask

    task automatic dn_idle();
        master_waitrequest   = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata      = '0;
        master_endofpacket   = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_swait"}, slave_waitrequest, 0);
        chk({tag, "_srdv"}, slave_readdatavalid, 0);
        chk({tag, "_seop"}, slave_endofpacket, 0);
        chk({tag, "_srdata"}, slave_readdata, 0);
        chk({tag, "_mread"}, master_read, 0);
        chk({tag, "_mwrite"}, master_write, 0);
        chk({tag, "_pending"}, reads_pending, 0);
        chk({tag, "_err"}, err_unexpected_rsp, 0);
    endtask

    task automatic ref_sample();
        cmd_t c;
        chk("rnd_pending", reads_pending, model_pend);
        chk("rnd_pending_max", reads_pending <= RSP_DEPTH, 1);
        chk("rnd_err", err_unexpected_rsp, 0);
        chk("rnd_rsp_valid", slave_readdatavalid, exp_rv);
        if (exp_rv && slave_readdatavalid) begin
            chk("rnd_rsp_data", slave_readdata, exp_rd);
            chk("rnd_rsp_eop", slave_endofpacket, exp_eop);
        end
        exp_rv  = master_readdatavalid && (model_pend > 0);
        exp_rd  = master_readdata;
        exp_eop = master_endofpacket;
        if (master_readdatavalid && model_pend > 0) model_pend--;
        if (stall_prev) begin
            chk("rnd_stall_ctl",
                {master_read, master_write, master_address, master_byteenable}, snap_ctl);
            chk("rnd_stall_data", master_writedata, snap_data);
        end
        if ((master_read || master_write) && !master_waitrequest) begin
            if (exp_cmd.size() == 0) begin
                chk("rnd_cmd_unexpected", {master_read, master_write}, 2'b00);
            end else begin
                c = exp_cmd.pop_front();
                chk("rnd_cmd_kind", {master_read, master_write}, {c.rd, c.wr});
                chk("rnd_cmd_addr", master_nativeaddress, c.addr);
                chk("rnd_cmd_byteaddr", master_address, {c.addr, 2'b00});
                chk("rnd_cmd_be", master_byteenable, c.be);
                if (c.wr) chk("rnd_cmd_wdata", master_writedata, c.wdata);
                if (c.rd) begin
                    model_pend++;
                    dn_owed++;
                end
            end
        end
        stall_prev = (master_read || master_write) && master_waitrequest;
        snap_ctl   = {master_read, master_write, master_address, master_byteenable};
        snap_data  = master_writedata;
        up_acc = (slave_read || slave_write) && !slave_waitrequest;
        if (up_acc)
            exp_cmd.push_back({slave_read, slave_write, slave_address,
                               slave_byteenable, slave_writedata});
    endtask

    task automatic tick();
        @(negedge clk);
        if (ref_en) ref_sample();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[4];
    int   sent, issued, first_c, last_c;
    logic acc;
    bit   req, done;

    initial begin
        vecs[0] = '{1'b0, 25'h0000010, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 27'h0000040};
        vecs[1] = '{1'b1, 25'h1FFFFFF, 4'h3, 32'h0, 32'hCAFEF00D, 1'b1, 27'h7FFFFFC};
        vecs[2] = '{1'b0, 25'h0000000, 4'h1, 32'h000000A5, 32'h0, 1'b0, 27'h0000000};
        vecs[3] = '{1'b1, 25'h0123456, 4'h8, 32'h0, 32'h5A5A5A5A, 1'b0, 27'h048D158};

        reset_n = 1'b0;
        up_idle();
        dn_idle();
        #3;
        check_zero("rst_hold");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();
        check_zero("rst_post");

        // Table-driven single transactions
        foreach (vecs[i]) begin
            slave_read       = vecs[i].rd;
            slave_write      = !vecs[i].rd;
            slave_address    = vecs[i].addr;
            slave_byteenable = vecs[i].be;
            slave_writedata  = vecs[i].wdata;
            chk("vec_accept", slave_waitrequest, 0);
            tick();
            up_idle();
            chk("vec_mread", master_read, vecs[i].rd);
            chk("vec_mwrite", master_write, !vecs[i].rd);
            chk("vec_maddr", master_address, vecs[i].exp_maddr);
            chk("vec_native", master_nativeaddress, vecs[i].addr);
            chk("vec_be", master_byteenable, vecs[i].be);
            if (!vecs[i].rd) chk("vec_wdata", master_writedata, vecs[i].wdata);
            tick();
            chk("vec_oneshot", {master_read, master_write}, 2'b00);
            if (vecs[i].rd) begin
                chk("vec_pend", reads_pending, 1);
                master_readdatavalid = 1'b1;
                master_readdata      = vecs[i].rdata;
                master_endofpacket   = vecs[i].eop;
                chk("vec_rsp_early", slave_readdatavalid, 0);
                tick();
                dn_idle();
                chk("vec_rsp_valid", slave_readdatavalid, 1);
                chk("vec_rsp_data", slave_readdata, vecs[i].rdata);
                chk("vec_rsp_eop", slave_endofpacket, vecs[i].eop);
                chk("vec_pend_done", reads_pending, 0);
                tick();
                chk("vec_rsp_once", slave_readdatavalid, 0);
            end
        end

        // Backpressure: fill command FIFO while downstream stalls
        master_waitrequest = 1'b1;
        sent = 0;
        for (int cyc = 0; cyc < 30 && sent < 8; cyc++) begin
            slave_write      = 1'b1;
            slave_address    = 25'h100 + 25'(sent);
            slave_byteenable = 4'hF;
            slave_writedata  = 32'h1000 + 32'(sent);
            acc = !slave_waitrequest;
            tick();
            if (acc) sent++;
            if (sent > 0) chk("bp_hold_addr", master_address, 27'h400);
        end
        chk("bp_sent", sent, 8);
        slave_address   = 25'h108;
        slave_writedata = 32'h1008;
        chk("bp_full_wait", slave_waitrequest, 1);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("bp_stall_write", master_write, 1);
            chk("bp_stall_addr", master_address, 27'h400);
            chk("bp_stall_data", master_writedata, 32'h1000);
            chk("bp_stall_wait", slave_waitrequest, 1);
        end
        master_waitrequest = 1'b0;
        issued = 0; first_c = 0; last_c = 0;
        for (int cyc = 0; cyc < 30 && issued < 9; cyc++) begin
            acc = slave_write && !slave_waitrequest;
            if (master_write) begin
                chk("bp_order_addr", master_nativeaddress, 25'h100 + 25'(issued));
                chk("bp_order_data", master_writedata, 32'h1000 + 32'(issued));
                if (issued == 0) first_c = cyc;
                last_c = cyc;
                issued++;
            end
            tick();
            if (acc) slave_write = 1'b0;
        end
        up_idle();
        chk("bp_issued", issued, 9);
        chk("bp_back_to_back", last_c - first_c, 8);
        chk("bp_idle", master_write, 0);

        // Credit: 20 reads, no responses
        sent = 0; issued = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (sent < 20) begin
                slave_read       = 1'b1;
                slave_address    = 25'h200 + 25'(sent);
                slave_byteenable = 4'hF;
            end else begin
                slave_read = 1'b0;
            end
            acc = slave_read && !slave_waitrequest;
            if (master_read) issued++;
            tick();
            if (acc) sent++;
        end
        up_idle();
        chk("cr_sent", sent, 20);
        chk("cr_issued", issued, 16);
        chk("cr_pending", reads_pending, 16);
        chk("cr_gated", master_read, 0);
        master_readdatavalid = 1'b1;
        master_readdata      = 32'h33333333;
        tick();
        dn_idle();
        chk("cr_reissue", master_read, 1);
        chk("cr_reissue_addr", master_nativeaddress, 25'h210);
        chk("cr_pending_dec", reads_pending, 15);
        chk("cr_rsp", slave_readdatavalid, 1);
        tick();
        chk("cr_pending_full", reads_pending, 16);
        chk("cr_regated", master_read, 0);

        // Response timing: two back-to-back responses, issue blocked meanwhile
        master_waitrequest   = 1'b1;
        master_readdatavalid = 1'b1;
        master_readdata      = 32'h11111111;
        master_endofpacket   = 1'b0;
        tick();
        master_readdata    = 32'h22222222;
        master_endofpacket = 1'b1;
        chk("rt_v1", slave_readdatavalid, 1);
        chk("rt_d1", slave_readdata, 32'h11111111);
        chk("rt_e1", slave_endofpacket, 0);
        chk("rt_p1", reads_pending, 15);
        tick();
        master_readdatavalid = 1'b0;
        chk("rt_v2", slave_readdatavalid, 1);
        chk("rt_d2", slave_readdata, 32'h22222222);
        chk("rt_e2", slave_endofpacket, 1);
        chk("rt_p2", reads_pending, 14);
        tick();
        chk("rt_v3", slave_readdatavalid, 0);
        chk("rt_stall_read", master_read, 1);

        // Reset mid-burst
        reset_n = 1'b0;
        dn_idle();
        #1;
        check_zero("mid_rst_hold");
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_zero("mid_rst_post");
        end

        // Unexpected response
        master_readdatavalid = 1'b1;
        master_readdata      = 32'h0BAD0BAD;
        tick();
        dn_idle();
        chk("pe_no_rsp", slave_readdatavalid, 0);
        chk("pe_err", err_unexpected_rsp, 1);
        chk("pe_pending", reads_pending, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("pe_sticky", err_unexpected_rsp, 1);
            chk("pe_no_rsp_later", slave_readdatavalid, 0);
        end
        reset_n = 1'b0;
        #1;
        chk("pe_cleared", err_unexpected_rsp, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Randomized traffic against the transaction model
        ref_en = 1;
        req = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (req && up_acc) begin
                req = 0;
                up_idle();
            end
            if (!req && $urandom_range(0, 99) < 60) begin
                req              = 1;
                slave_read       = 1'($urandom_range(0, 1));
                slave_write      = !slave_read;
                slave_address    = 25'($urandom);
                slave_byteenable = 4'($urandom_range(1, 15));
                slave_writedata  = $urandom;
            end
            master_waitrequest = ($urandom_range(0, 3) == 0);
            if (dn_owed > 0 && $urandom_range(0, 1) == 1) begin
                master_readdatavalid = 1'b1;
                master_readdata      = $urandom;
                master_endofpacket   = 1'($urandom_range(0, 1));
                dn_owed--;
            end else begin
                master_readdatavalid = 1'b0;
            end
            tick();
        end
        done = 0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (req && up_acc) begin
                req = 0;
                up_idle();
            end
            done = !req && exp_cmd.size() == 0 && dn_owed == 0 && model_pend == 0 && !exp_rv;
            master_waitrequest = ($urandom_range(0, 3) == 0);
            if (dn_owed > 0 && $urandom_range(0, 1) == 1) begin
                master_readdatavalid = 1'b1;
                master_readdata      = $urandom;
                master_endofpacket   = 1'($urandom_range(0, 1));
                dn_owed--;
            end else begin
                master_readdatavalid = 1'b0;
            end
            tick();
        end
        chk("rnd_drain_done", done, 1);
        ref_en = 0;
        dn_idle();
        up_idle();
        tick();
        chk("rnd_final_pending", reads_pending, 0);
        chk("rnd_final_idle", {master_read, master_write}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avalon_mm_pipeline_bridge.md
Name: avalon_mm_pipeline_bridge

Overview:
- Single-clock, parametrised Avalon-MM slave-to-master bridge with buffering.
- Successor to the team's fixed-width clock-crossing bridges for same-domain paths: configurable data/address width and FIFO depths.
- Decouples an upstream master (s-port) from a downstream slave (m-port).
- Credit-based read gating guarantees response-buffer no-overflow; adds outstanding-read tracking and protocol-error flagging.

Parameters:
DATA_W, 32, data width in bits; multiple of 8, 8..256; BE_W = DATA_W/8
ADDR_W, 25, word-address width
CMD_DEPTH, 8, command FIFO entries; power of 2, >=2
RSP_DEPTH, 16, response FIFO entries; power of 2, >=2; also the maximum reads in flight

Ports:
clk  in  1  single clock for all logic
reset_n  in  1  asynchronous active-low reset
slave_address  in  ADDR_W  word address
slave_byteenable  in  BE_W  byte enables
slave_read  in  1  read request
slave_write  in  1  write request; read and write are never both high
slave_writedata  in  DATA_W  write data
slave_waitrequest  out  1  command not accepted this cycle
slave_readdata  out  DATA_W  read response data
slave_readdatavalid  out  1  read response valid
slave_endofpacket  out  1  endofpacket carried with the response
master_address  out  ADDR_W+log2(BE_W)  byte address = {word addr, zeros}
master_nativeaddress  out  ADDR_W  word address
master_byteenable  out  BE_W  byte enables
master_read  out  1  read command
master_write  out  1  write command
master_writedata  out  DATA_W  write data
master_waitrequest  in  1  downstream stall
master_readdata  in  DATA_W  response data
master_readdatavalid  in  1  response valid
master_endofpacket  in  1  endofpacket
reads_pending  out  log2(RSP_DEPTH)+1  reads issued and not yet returned
err_unexpected_rsp  out  1  sticky: readdatavalid seen with reads_pending==0

Behaviour:
- Reset: async assert clears both FIFOs, counters and err flag. All outputs 0 during and after reset, except data/address outputs, which are don't-care while read/write are 0. A reset mid-transfer discards all queued and in-flight state; responses arriving after reset for pre-reset reads count as unexpected.
- Command accept:
  - slave_waitrequest = (cmd_count == CMD_DEPTH), from registered state only; no combinational path from slave_read or slave_write.
  - Push {writedata, address, byteenable, rd, wr} when (slave_read|slave_write) & !slave_waitrequest.
- Command issue: the command FIFO is show-ahead.
  - When non-empty, the head drives master_* outputs.
  - master_write = head_wr.
  - master_read = head_rd & credit, where credit = (reads_pending + rsp_count < RSP_DEPTH).
  - A command is accepted downstream when (master_read|master_write) & !master_waitrequest; that cycle pops the head.
  - While master_waitrequest is high, all master_* outputs hold stable. This holds because credit cannot decrease while a read is held.
  - Minimum latency: slave push in cycle N -> master_read/master_write in cycle N+1.
  - Push into a full FIFO is impossible. Push and pop in the same cycle leaves cmd_count unchanged (legal at full only because waitrequest blocks the push).
- reads_pending counter:
  - +1 on an accepted read; -1 on master_readdatavalid while reads_pending > 0; both in the same cycle -> unchanged.
  - Never exceeds RSP_DEPTH.
- Response path:
  - master_readdatavalid pushes {readdata, endofpacket} into the response FIFO.
  - If reads_pending == 0 at that edge: no push, err_unexpected_rsp set (sticky until reset).
  - Drain: every cycle the FIFO is non-empty, pop the head into registered outputs and set slave_readdatavalid = 1 for that cycle; otherwise 0. There is no backpressure.
  - Latency: master_readdatavalid in cycle N -> slave_readdatavalid in cycle N+1 (first-word fall-through).
  - Throughput: one response per cycle.
- Ordering: strict; responses are returned in issue order.
- Response FIFO overflow is impossible given the credit rule. The bench asserts it.

Test Plan:
- Reset: assert reset_n=0 mid-burst, then release -> all outputs 0; reads_pending=0; err_unexpected_rsp=0; no master_read/master_write until a new command is pushed.
- Single write: addr 0x000010, byteenable 0xF, data 0xDEADBEEF, master_waitrequest=0 -> cycle+1: master_write=1, master_address=0x40, master_nativeaddress=0x10, master_writedata=0xDEADBEEF, for exactly one cycle.
- Backpressure: push 9 writes with master_waitrequest=1 -> slave_waitrequest=1 after the 8th accept. Release waitrequest -> 9 writes issue in order, one per cycle, and master_* stay stable throughout each stall.
- Credit:
  - Setup: RSP_DEPTH=16, 20 queued reads, no responses.
  - Expected: master_read drops after 16 accepts; reads_pending=16.
  - Then: one readdatavalid -> one more read issues the next cycle.
- Response timing: return 0x11111111 (eop=0) then 0x22222222 (eop=1) on consecutive cycles -> slave_readdatavalid high in cycles N+1 and N+2 with the same data and eop, in order; reads_pending decrements by 2.
- Protocol error: master_readdatavalid=1 with reads_pending=0 -> no slave_readdatavalid; err_unexpected_rsp=1, staying high until reset.
